// File: rtl/fpu_pkg.sv
// Shared definitions for the single-precision add/multiply unit: field widths,
// the canonical quiet NaN, operand unpacking and the nearest-even round decision.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int WORD_W = 1 + EXP_W + FRAC_W;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
    } fp_fields_t;

    // Split a binary32 word into fields; a zero exponent (zero or denormal)
    // is reported as zero so denormal inputs are flushed.
    function automatic fp_fields_t unpack_fp(input logic [31:0] x);
        fp_fields_t f;
        f.sign    = x[31];
        f.exp     = x[30:23];
        f.frac    = x[22:0];
        f.is_zero = (x[30:23] == 8'h00);
        f.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h000000);
        f.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h000000);
        return f;
    endfunction

    // Round-to-nearest, ties-to-even: increment when above half, or exactly
    // half with an odd LSB.
    function automatic logic rne_round_up(input logic lsb, input logic guard,
                                          input logic rnd, input logic sticky);
        return guard & (rnd | sticky | lsb);
    endfunction

endpackage

// File: rtl/fpu_if.sv
// Operand/result bundle of the FP unit. The driver owns A, B and control;
// the unit owns result.
interface fpu_if;
    import fpu_pkg::*;

    logic [WORD_W-1:0] A;
    logic [WORD_W-1:0] B;
    logic              control;
    logic [WORD_W-1:0] result;

    modport master (output A, output B, output control, input result);
    modport slave  (input A, input B, input control, output result);

endinterface

// File: rtl/fpu_round_pack.sv
// Rounds a normalized 24-bit significand with guard/round/sticky to nearest
// even, renormalizes on a rounding carry, range-checks the exponent and packs
// a binary32 word. Overflow gives signed infinity, underflow signed zero.
module fpu_round_pack
    import fpu_pkg::*;
(
    input  logic              sign_s,
    input  logic signed [9:0] exp_s,     // unbiased exponent, value = 1.f * 2^exp
    input  logic [23:0]       sig_s,     // bit 23 is the hidden one
    input  logic              guard_s,
    input  logic              round_s,
    input  logic              sticky_s,
    output logic [31:0]       result_s
);

    logic               inc_s;
    logic [24:0]        sum_s;
    logic [22:0]        frac_s;
    logic signed [10:0] bexp_s;

    // Round, renormalize on carry-out, then pick infinity, zero or the packed value.
    always_comb begin
        inc_s  = rne_round_up(sig_s[0], guard_s, round_s, sticky_s);
        sum_s  = {1'b0, sig_s} + {24'd0, inc_s};
        bexp_s = {exp_s[9], exp_s} + 11'sd127;
        if (sum_s[24]) begin
            bexp_s = bexp_s + 11'sd1;
            frac_s = sum_s[23:1];
        end else begin
            frac_s = sum_s[22:0];
        end
        if (bexp_s >= 11'sd255) begin
            result_s = {sign_s, 8'hFF, 23'd0};
        end else if (bexp_s <= 11'sd0) begin
            result_s = {sign_s, 31'd0};
        end else begin
            result_s = {sign_s, bexp_s[7:0], frac_s};
        end
    end

endmodule

// File: rtl/fpu.sv
// Single-precision add (control=0) / multiply (control=1) with a registered
// result: one operation accepted per clock, result one clock later.
module fpu
    import fpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    fpu_if.slave  bus
);

    fp_fields_t fa_s;
    fp_fields_t fb_s;

    // add path
    logic              swap_s;
    logic              big_sign_s;
    logic [7:0]        big_exp_s;
    logic [7:0]        small_exp_s;
    logic [23:0]       big_sig_s;
    logic [23:0]       small_sig_s;
    logic [7:0]        diff_s;
    logic [49:0]       shifted_s;
    logic [27:0]       big_w_s;      // {carry, sig[23:0], G, R, S}
    logic [27:0]       small_w_s;
    logic [27:0]       sum_w_s;
    logic [4:0]        lz_s;
    logic [26:0]       norm_s;
    logic [23:0]       add_sig_s;
    logic              add_g_s;
    logic              add_r_s;
    logic              add_st_s;
    logic signed [9:0] add_exp_s;
    logic [31:0]       add_packed_s;
    logic [31:0]       add_res_s;

    // multiply path
    logic [47:0]       prod_s;
    logic [23:0]       mul_sig_s;
    logic              mul_g_s;
    logic              mul_r_s;
    logic              mul_st_s;
    logic              mul_sign_s;
    logic signed [9:0] mul_exp_s;
    logic [31:0]       mul_packed_s;
    logic [31:0]       mul_res_s;

    logic [31:0]       next_res_s;
    logic [31:0]       result_r;

    assign fa_s = unpack_fp(bus.A);
    assign fb_s = unpack_fp(bus.B);

    // Order operands by magnitude, align the smaller one and add/subtract magnitudes.
    always_comb begin
        swap_s = ({fb_s.exp, fb_s.frac} > {fa_s.exp, fa_s.frac});
        if (swap_s) begin
            big_sign_s  = fb_s.sign;
            big_exp_s   = fb_s.exp;
            big_sig_s   = {1'b1, fb_s.frac};
            small_exp_s = fa_s.exp;
            small_sig_s = {1'b1, fa_s.frac};
        end else begin
            big_sign_s  = fa_s.sign;
            big_exp_s   = fa_s.exp;
            big_sig_s   = {1'b1, fa_s.frac};
            small_exp_s = fb_s.exp;
            small_sig_s = {1'b1, fb_s.frac};
        end
        diff_s    = big_exp_s - small_exp_s;
        shifted_s = {small_sig_s, 26'd0} >> diff_s;
        big_w_s   = {1'b0, big_sig_s, 3'b000};
        // Beyond 25 positions the smaller operand only contributes to sticky.
        if (diff_s >= 8'd26) begin
            small_w_s = 28'd1;
        end else begin
            small_w_s = {1'b0, shifted_s[49:24], |shifted_s[23:0]};
        end
        if (fa_s.sign == fb_s.sign) begin
            sum_w_s = big_w_s + small_w_s;
        end else begin
            sum_w_s = big_w_s - small_w_s;
        end
    end

    // Normalize the raw sum: right by one on carry-out, else left by the leading-zero count.
    always_comb begin
        lz_s = 5'd0;
        for (int i = 0; i < 27; i++) begin
            lz_s = sum_w_s[i] ? 5'(26 - i) : lz_s;
        end
        norm_s = sum_w_s[26:0] << lz_s;
        if (sum_w_s[27]) begin
            add_sig_s = sum_w_s[27:4];
            add_g_s   = sum_w_s[3];
            add_r_s   = sum_w_s[2];
            add_st_s  = sum_w_s[1] | sum_w_s[0];
            add_exp_s = $signed({2'b00, big_exp_s}) - 10'sd126;
        end else begin
            add_sig_s = norm_s[26:3];
            add_g_s   = norm_s[2];
            add_r_s   = norm_s[1];
            add_st_s  = norm_s[0];
            add_exp_s = $signed({2'b00, big_exp_s}) - 10'sd127 - $signed({5'd0, lz_s});
        end
    end

    // Multiply significands and normalize the 48-bit product to 24 bits plus G/R/S.
    always_comb begin
        mul_sign_s = fa_s.sign ^ fb_s.sign;
        prod_s     = 48'({1'b1, fa_s.frac}) * 48'({1'b1, fb_s.frac});
        if (prod_s[47]) begin
            mul_sig_s = prod_s[47:24];
            mul_g_s   = prod_s[23];
            mul_r_s   = prod_s[22];
            mul_st_s  = |prod_s[21:0];
            mul_exp_s = $signed({2'b00, fa_s.exp}) + $signed({2'b00, fb_s.exp}) - 10'sd253;
        end else begin
            mul_sig_s = prod_s[46:23];
            mul_g_s   = prod_s[22];
            mul_r_s   = prod_s[21];
            mul_st_s  = |prod_s[20:0];
            mul_exp_s = $signed({2'b00, fa_s.exp}) + $signed({2'b00, fb_s.exp}) - 10'sd254;
        end
    end

    fpu_round_pack u_add_round (
        .sign_s   (big_sign_s),
        .exp_s    (add_exp_s),
        .sig_s    (add_sig_s),
        .guard_s  (add_g_s),
        .round_s  (add_r_s),
        .sticky_s (add_st_s),
        .result_s (add_packed_s)
    );

    fpu_round_pack u_mul_round (
        .sign_s   (mul_sign_s),
        .exp_s    (mul_exp_s),
        .sig_s    (mul_sig_s),
        .guard_s  (mul_g_s),
        .round_s  (mul_r_s),
        .sticky_s (mul_st_s),
        .result_s (mul_packed_s)
    );

    // Override the add result for NaN, infinity, zero operands and exact cancellation.
    always_comb begin
        if (fa_s.is_nan || fb_s.is_nan) begin
            add_res_s = QNAN;
        end else if (fa_s.is_inf && fb_s.is_inf) begin
            add_res_s = (fa_s.sign != fb_s.sign) ? QNAN : bus.A;
        end else if (fa_s.is_inf) begin
            add_res_s = bus.A;
        end else if (fb_s.is_inf) begin
            add_res_s = bus.B;
        end else if (fa_s.is_zero && fb_s.is_zero) begin
            add_res_s = {fa_s.sign & fb_s.sign, 31'd0};
        end else if (fa_s.is_zero) begin
            add_res_s = bus.B;
        end else if (fb_s.is_zero) begin
            add_res_s = bus.A;
        end else if (sum_w_s == 28'd0) begin
            add_res_s = 32'h00000000;
        end else begin
            add_res_s = add_packed_s;
        end
    end

    // Override the multiply result for NaN, infinity and zero operands.
    always_comb begin
        if (fa_s.is_nan || fb_s.is_nan) begin
            mul_res_s = QNAN;
        end else if ((fa_s.is_inf && fb_s.is_zero) || (fb_s.is_inf && fa_s.is_zero)) begin
            mul_res_s = QNAN;
        end else if (fa_s.is_inf || fb_s.is_inf) begin
            mul_res_s = {mul_sign_s, 8'hFF, 23'd0};
        end else if (fa_s.is_zero || fb_s.is_zero) begin
            mul_res_s = {mul_sign_s, 31'd0};
        end else begin
            mul_res_s = mul_packed_s;
        end
    end

    // Select the operation requested this cycle.
    always_comb begin
        if (bus.control) begin
            next_res_s = mul_res_s;
        end else begin
            next_res_s = add_res_s;
        end
    end

    // Result register; reset wins over the operation sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= 32'h00000000;
        end else begin
            result_r <= next_res_s;
        end
    end

    assign bus.result = result_r;

endmodule

// File: tb/tb_fpu.sv
// Directed and randomized checks of the FP add/multiply unit. Expected values
// come from constants or a real-number round-to-nearest-even model and travel
// through a scoreboard queue to the cycle the result is due.
`timescale 1ns/1ps
module tb_fpu;
    import fpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    fpu_if bus ();

    fpu dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    function automatic real f32_to_real(input logic [31:0] x);
        real v;
        int  e;
        if (x[30:23] == 8'h00) return 0.0;
        v = 1.0 + real'(int'(x[22:0])) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return x[31] ? -v : v;
    endfunction

    function automatic logic [31:0] real_to_f32(input real x);
        logic s;
        real  ax, m, rem;
        int   e, mi;
        s  = (x < 0.0);
        ax = s ? -x : x;
        if (ax == 0.0) return 32'h00000000;
        e = 0;
        while (ax >= 2.0) begin ax = ax / 2.0; e++; end
        while (ax < 1.0)  begin ax = ax * 2.0; e--; end
        m   = ax * 8388608.0;
        mi  = $rtoi(m);
        rem = m - real'(mi);
        if (rem > 0.5 || (rem == 0.5 && mi[0])) mi++;
        if (mi == 16777216) begin mi = 8388608; e++; end
        e = e + 127;
        if (e >= 255) return {s, 8'hFF, 23'h000000};
        if (e <= 0) return {s, 31'h00000000};
        return {s, e[7:0], mi[22:0]};
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic ctl);
        if (ctl) return real_to_f32(f32_to_real(a) * f32_to_real(b));
        return real_to_f32(f32_to_real(a) + f32_to_real(b));
    endfunction

    function automatic logic [31:0] rand_norm();
        logic [31:0] r;
        r = $urandom;
        return {r[31], 8'(120 + $urandom_range(14)), r[22:0]};
    endfunction

    // Apply one operation at the falling edge, queue its expectation and step
    // to just after the edge that registers it.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ctl,
                         input logic r, input logic [31:0] e, input string nm);
        @(negedge clk);
        bus.A       = a;
        bus.B       = b;
        bus.control = ctl;
        rst         = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] va[5], vb[5], ve[5], e;
        logic        vc[5], vr[5];
        string       n;
        va = '{32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h41400000, 32'h41400000};
        vb = '{32'h40100000, 32'h40100000, 32'h40100000, 32'h3F000000, 32'h3F000000};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vr = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        ve = '{32'h00000000, 32'h00000000, 32'h40700000, 32'h00000000, 32'h40C00000};
        for (int i = 0; i < 5; i++) begin
            drive(va[i], vb[i], vc[i], vr[i], ve[i], $sformatf("reset[%0d]", i));
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests_run++;
            if (bus.result !== e) begin
                tests_failed++;
                $display("FAIL %s: result=%h expected=%h", n, bus.result, e);
            end
        end
    endtask

    task automatic test_add();
        logic [31:0] va[6], vb[6], ve[6], e;
        string       n;
        va = '{32'h3FC00000, 32'h41400000, 32'h40000000, 32'h40B570A4, 32'h43ADFD2F, 32'h7F7FFFFF};
        vb = '{32'h40100000, 32'h3F000000, 32'hC0000000, 32'h3EE147AE, 32'h3A4C78EA, 32'h7F7FFFFF};
        ve = '{32'h40700000, 32'h41480000, 32'h00000000, 32'h40C3851F, 32'h00000000, 32'h7F800000};
        ve[4] = model(va[4], vb[4], 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(va[i], vb[i], 1'b0, 1'b0, ve[i], $sformatf("add[%0d]", i));
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests_run++;
            if (bus.result !== e) begin
                tests_failed++;
                $display("FAIL %s: result=%h expected=%h", n, bus.result, e);
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] va[4], vb[4], ve[4], e;
        string       n;
        va = '{32'h3FC00000, 32'h41400000, 32'h40B570A4, 32'h41400000};
        vb = '{32'h40100000, 32'h3F000000, 32'h3EE147AE, 32'h3D4779A7};
        ve = '{32'h40580000, 32'h40C00000, 32'h00000000, 32'h00000000};
        ve[2] = model(va[2], vb[2], 1'b1);
        ve[3] = model(va[3], vb[3], 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(va[i], vb[i], 1'b1, 1'b0, ve[i], $sformatf("mul[%0d]", i));
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests_run++;
            if (bus.result !== e) begin
                tests_failed++;
                $display("FAIL %s: result=%h expected=%h", n, bus.result, e);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va[12], vb[12], ve[12], e;
        logic        vc[12];
        string       n;
        va = '{32'h7F800000, 32'h7F800000, 32'h7F7FFFFF, 32'h00800000, 32'h7F800001, 32'h00000000,
               32'h80000000, 32'h7F800000, 32'h80000000, 32'h7F800000, 32'h00400000, 32'hFF800000};
        vb = '{32'hFF800000, 32'h00000000, 32'h40000000, 32'h00800000, 32'h3F800000, 32'hC0400000,
               32'h00000000, 32'hC0000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'hFF800000};
        vc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        ve = '{32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hC0400000,
               32'h00000000, 32'hFF800000, 32'h80000000, 32'h7F800000, 32'h00000000, 32'hFF800000};
        for (int i = 0; i < 12; i++) begin
            drive(va[i], vb[i], vc[i], 1'b0, ve[i], $sformatf("special[%0d]", i));
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests_run++;
            if (bus.result !== e) begin
                tests_failed++;
                $display("FAIL %s: result=%h expected=%h", n, bus.result, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, e;
        logic        ctl;
        string       n;
        for (int i = 0; i < 48; i++) begin
            ctl = logic'(i % 2);
            if (i == 0) begin
                a = 32'h3F800000;
                b = 32'h33800000;
                e = 32'h3F800000;
            end else begin
                a = rand_norm();
                b = rand_norm();
                e = model(a, b, ctl);
            end
            drive(a, b, ctl, 1'b0, e, $sformatf("b2b[%0d] %h %s %h", i, a, ctl ? "*" : "+", b));
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests_run++;
            if (bus.result !== e) begin
                tests_failed++;
                $display("FAIL %s: result=%h expected=%h", n, bus.result, e);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.A       = 32'h00000000;
        bus.B       = 32'h00000000;
        bus.control = 1'b0;
        test_reset();
        test_add();
        test_mul();
        test_specials();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
